// File: rtl/conv_window_fetch_if.sv
// Feature-RAM read port and MAC-side tap stream of conv_window_fetch.
// The fetch unit is the master and the RAM/MAC side is the slave.
interface conv_window_fetch_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1,
    parameter int ADDR_WIDTH = 16
);
    logic                           mem_rd_en;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic [DATA_WIDTH*CHANNELS-1:0] mem_rd_data;
    logic                           pix_valid;
    logic                           pix_ready;
    logic [DATA_WIDTH*CHANNELS-1:0] pix_data;
    logic                           pix_padded;
    logic                           pix_win_last;
    logic                           pix_frame_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rd_data,
        output pix_valid, pix_data, pix_padded, pix_win_last, pix_frame_last,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rd_data,
        input  pix_valid, pix_data, pix_padded, pix_win_last, pix_frame_last,
        output pix_ready
    );
endinterface

// File: rtl/conv_window_fetch.sv
// Convolution window fetcher: validates a config, derives the output size by
// repeated subtraction, then streams every kernel tap (RAM word or padding).
module conv_window_fetch #(
    parameter int                    COORD_WIDTH = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CHANNELS    = 1,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] cfg_in_height,
    input  logic [COORD_WIDTH-1:0] cfg_in_width,
    input  logic [COORD_WIDTH-1:0] cfg_kernel,
    input  logic [COORD_WIDTH-1:0] cfg_stride,
    input  logic [COORD_WIDTH-1:0] cfg_padding,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_error,
    output logic [COORD_WIDTH-1:0] out_height,
    output logic [COORD_WIDTH-1:0] out_width,
    conv_window_fetch_if.master    bus
);
    localparam int CW    = COORD_WIDTH;
    localparam int LIN_W = 2 * COORD_WIDTH;

    typedef enum logic [2:0] {IDLE, CHECK, SETUP, RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [CW-1:0]        h, w, k, s, p;
    logic [CW+1:0]        span_h, span_w, rem_h, rem_w, s_ext;
    logic [CW-1:0]        q_h, q_w;
    logic                 cfg_bad, div_done;
    logic [CW-1:0]        oy, ox, ky, kx;
    logic signed [CW:0]   base_y, base_x, iy, ix, s_signed, neg_p;
    logic                 kx_last, ky_last, ox_last, oy_last;
    logic                 tap_in_range, tap_win_last, tap_frame_last;
    logic [LIN_W-1:0]     lin_addr;
    logic                 s1_valid, s1_padded, s1_win_last, s1_frame_last;
    logic                 s2_load, issue, last_accept, done_q;

    // Padded extents H+2P and W+2P carry two extra bits so they never wrap.
    assign span_h   = {2'b00, h} + {1'b0, p, 1'b0};
    assign span_w   = {2'b00, w} + {1'b0, p, 1'b0};
    assign s_ext    = {2'b00, s};
    assign cfg_bad  = (k == '0) || (s == '0) || ({2'b00, k} > span_h) || ({2'b00, k} > span_w);
    assign div_done = (rem_h < s_ext) && (rem_w < s_ext);

    assign s_signed = $signed({1'b0, s});
    assign neg_p    = -$signed({1'b0, p});
    assign iy       = base_y + $signed({1'b0, ky});
    assign ix       = base_x + $signed({1'b0, kx});

    assign kx_last        = (kx == k - 1'b1);
    assign ky_last        = (ky == k - 1'b1);
    assign ox_last        = (ox == out_width - 1'b1);
    assign oy_last        = (oy == out_height - 1'b1);
    assign tap_win_last   = kx_last && ky_last;
    assign tap_frame_last = tap_win_last && ox_last && oy_last;
    assign tap_in_range   = !iy[CW] && (iy[CW-1:0] < h) && !ix[CW] && (ix[CW-1:0] < w);

    assign lin_addr = LIN_W'(iy[CW-1:0]) * LIN_W'(w) + LIN_W'(ix[CW-1:0]);
    assign bus.mem_addr = ADDR_WIDTH'(lin_addr);

    // S2 refills whenever it is empty or being consumed; S1 refills behind it.
    assign s2_load     = s1_valid && (!bus.pix_valid || bus.pix_ready);
    assign issue       = (state == RUN) && (!s1_valid || s2_load);
    assign last_accept = bus.pix_valid && bus.pix_ready && bus.pix_frame_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = cfg_bad ? IDLE : SETUP;
            SETUP:   if (div_done) state_next = RUN;
            RUN:     if (issue && tap_frame_last) state_next = DRAIN;
            DRAIN:   if (last_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == SETUP) || (state == RUN) || (state == DRAIN);
        cfg_error     = (state == CHECK) && cfg_bad;
        bus.mem_rd_en = issue && tap_in_range;
        done          = done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {h, w, k, s, p}        <= '0;
            {rem_h, rem_w}         <= '0;
            {q_h, q_w}             <= '0;
            {out_height, out_width} <= '0;
        end else begin
            if (state == IDLE && start) begin
                h <= cfg_in_height;
                w <= cfg_in_width;
                k <= cfg_kernel;
                s <= cfg_stride;
                p <= cfg_padding;
            end
            if (state == CHECK) begin
                rem_h <= span_h - {2'b00, k};
                rem_w <= span_w - {2'b00, k};
                q_h   <= '0;
                q_w   <= '0;
            end else if (state == SETUP) begin
                if (rem_h >= s_ext) begin rem_h <= rem_h - s_ext; q_h <= q_h + 1'b1; end
                if (rem_w >= s_ext) begin rem_w <= rem_w - s_ext; q_w <= q_w + 1'b1; end
                if (div_done) begin
                    out_height <= q_h + 1'b1;
                    out_width  <= q_w + 1'b1;
                end
            end
        end
    end

    // Scan counters: kx fastest, then ky, ox, oy; bases track oy*S-P and ox*S-P.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {oy, ox, ky, kx} <= '0;
            base_y <= '0;
            base_x <= '0;
        end else if (state == SETUP && div_done) begin
            {oy, ox, ky, kx} <= '0;
            base_y <= neg_p;
            base_x <= neg_p;
        end else if (issue) begin
            if (!kx_last) kx <= kx + 1'b1;
            else begin
                kx <= '0;
                if (!ky_last) ky <= ky + 1'b1;
                else begin
                    ky <= '0;
                    if (!ox_last) begin
                        ox     <= ox + 1'b1;
                        base_x <= base_x + s_signed;
                    end else begin
                        ox     <= '0;
                        base_x <= neg_p;
                        oy     <= oy + 1'b1;
                        base_y <= base_y + s_signed;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1_valid, s1_padded, s1_win_last, s1_frame_last} <= '0;
            bus.pix_valid      <= 1'b0;
            bus.pix_data       <= '0;
            bus.pix_padded     <= 1'b0;
            bus.pix_win_last   <= 1'b0;
            bus.pix_frame_last <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            if (issue) begin
                s1_valid      <= 1'b1;
                s1_padded     <= !tap_in_range;
                s1_win_last   <= tap_win_last;
                s1_frame_last <= tap_frame_last;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                bus.pix_valid      <= 1'b1;
                bus.pix_data       <= s1_padded ? {CHANNELS{PAD_VALUE}} : bus.mem_rd_data;
                bus.pix_padded     <= s1_padded;
                bus.pix_win_last   <= s1_win_last;
                bus.pix_frame_last <= s1_frame_last;
            end else if (bus.pix_ready) begin
                bus.pix_valid <= 1'b0;
            end

            done_q <= (state == DRAIN) && last_accept;
        end
    end
endmodule

// File: tb/tb_conv_window_fetch.sv
// Self-checking bench for conv_window_fetch: a config table with a scoreboard
// of expected taps/addresses, plus stall, reset and multi-channel sequences.
module tb_conv_window_fetch;
    logic        clk = 1'b0;
    logic        rst, start_a, start_b, ready, sel;
    logic [15:0] cfg_h, cfg_w, cfg_k, cfg_s, cfg_p;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [15:0] oh_a, ow_a, oh_b, ow_b;

    always #5 clk = ~clk;

    conv_window_fetch_if #(.DATA_WIDTH(8), .CHANNELS(1), .ADDR_WIDTH(16)) bus_a ();
    conv_window_fetch_if #(.DATA_WIDTH(8), .CHANNELS(3), .ADDR_WIDTH(16)) bus_b ();

    conv_window_fetch #(.COORD_WIDTH(16), .DATA_WIDTH(8), .CHANNELS(1), .ADDR_WIDTH(16),
                        .PAD_VALUE(8'h00)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .cfg_in_height(cfg_h), .cfg_in_width(cfg_w), .cfg_kernel(cfg_k),
        .cfg_stride(cfg_s), .cfg_padding(cfg_p),
        .busy(busy_a), .done(done_a), .cfg_error(err_a),
        .out_height(oh_a), .out_width(ow_a), .bus(bus_a));

    conv_window_fetch #(.COORD_WIDTH(16), .DATA_WIDTH(8), .CHANNELS(3), .ADDR_WIDTH(16),
                        .PAD_VALUE(8'h80)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .cfg_in_height(cfg_h), .cfg_in_width(cfg_w), .cfg_kernel(cfg_k),
        .cfg_stride(cfg_s), .cfg_padding(cfg_p),
        .busy(busy_b), .done(done_b), .cfg_error(err_b),
        .out_height(oh_b), .out_width(ow_b), .bus(bus_b));

    assign bus_a.pix_ready = ready;
    assign bus_b.pix_ready = ready;

    function automatic logic [23:0] ram_word(input logic [15:0] addr);
        ram_word = {8'(addr ^ 16'h0055), 8'(addr * 3), 8'(addr + 1)};
    endfunction

    always_ff @(posedge clk) if (bus_a.mem_rd_en) bus_a.mem_rd_data <= 8'(ram_word(bus_a.mem_addr));
    always_ff @(posedge clk) if (bus_b.mem_rd_en) bus_b.mem_rd_data <= ram_word(bus_b.mem_addr);

    logic        mon_valid, mon_rd_en, mon_padded, mon_wl, mon_fl, mon_busy, mon_done, mon_err;
    logic [23:0] mon_data;
    logic [15:0] mon_addr, mon_oh, mon_ow;

    always_comb begin
        mon_valid  = sel ? bus_b.pix_valid      : bus_a.pix_valid;
        mon_rd_en  = sel ? bus_b.mem_rd_en      : bus_a.mem_rd_en;
        mon_padded = sel ? bus_b.pix_padded     : bus_a.pix_padded;
        mon_wl     = sel ? bus_b.pix_win_last   : bus_a.pix_win_last;
        mon_fl     = sel ? bus_b.pix_frame_last : bus_a.pix_frame_last;
        mon_data   = sel ? bus_b.pix_data       : {16'h0000, bus_a.pix_data};
        mon_addr   = sel ? bus_b.mem_addr       : bus_a.mem_addr;
        mon_busy   = sel ? busy_b : busy_a;
        mon_done   = sel ? done_b : done_a;
        mon_err    = sel ? err_b  : err_a;
        mon_oh     = sel ? oh_b   : oh_a;
        mon_ow     = sel ? ow_b   : ow_a;
    end

    typedef struct {
        logic [23:0] data;
        logic        padded;
        logic        win_last;
        logic        frame_last;
    } tap_t;

    typedef struct {
        int h, w, k, s, p;
        int oh, ow, taps, pads;
        bit err;
    } vec_t;

    tap_t        exp_q[$], recv_q[$], ref_q[$];
    logic [15:0] addr_q[$];
    int passed = 0;
    int total  = 0;
    int taps_n, pads_n, done_n, err_n, rd_n;
    bit busy_seen, done_busy, finished;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [26:0] pack_tap(input tap_t t);
        pack_tap = {t.data, t.padded, t.win_last, t.frame_last};
    endfunction

    // Reference model: direct coordinate arithmetic with true division.
    task automatic build_expected(input int h, w, k, s, p, input bit b);
        int oh, ow, iy, ix;
        tap_t t;
        logic [15:0] a;
        oh = (h + 2 * p - k) / s + 1;
        ow = (w + 2 * p - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        iy = oy * s - p + ky;
                        ix = ox * s - p + kx;
                        if (iy >= 0 && iy < h && ix >= 0 && ix < w) begin
                            a = 16'(iy * w + ix);
                            addr_q.push_back(a);
                            t.data   = b ? ram_word(a) : {16'h0000, 8'(ram_word(a))};
                            t.padded = 1'b0;
                        end else begin
                            t.data   = b ? 24'h808080 : 24'h000000;
                            t.padded = 1'b1;
                        end
                        t.win_last   = (ky == k - 1) && (kx == k - 1);
                        t.frame_last = t.win_last && (oy == oh - 1) && (ox == ow - 1);
                        exp_q.push_back(t);
                    end
    endtask

    task automatic run_frame(input int h, w, k, s, p, input bit b, input bit rnd, input bit legal);
        tap_t cur, held, e;
        bit stalled;
        int post;
        exp_q.delete(); addr_q.delete(); recv_q.delete();
        {taps_n, pads_n, done_n, err_n, rd_n} = '0;
        busy_seen = 1'b0; done_busy = 1'b0; finished = 1'b0;
        stalled = 1'b0; post = 0;
        @(negedge clk);
        sel = b;
        cfg_h = 16'(h); cfg_w = 16'(w); cfg_k = 16'(k); cfg_s = 16'(s); cfg_p = 16'(p);
        if (legal) build_expected(h, w, k, s, p, b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (mon_busy) busy_seen = 1'b1;
            if (mon_err) err_n++;
            if (mon_done) begin done_n++; done_busy = mon_busy; end
            if (mon_rd_en) begin
                rd_n++;
                if (addr_q.size() == 0) check("extra_read", 1, 0);
                else check("mem_addr", mon_addr, addr_q.pop_front());
            end
            if (mon_valid) begin
                cur = '{mon_data, mon_padded, mon_wl, mon_fl};
                if (stalled) check("stall_hold", pack_tap(cur), pack_tap(held));
                if (ready) begin
                    taps_n++;
                    if (mon_padded) pads_n++;
                    recv_q.push_back(cur);
                    if (exp_q.size() == 0) check("extra_tap", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check($sformatf("tap%0d", taps_n - 1), pack_tap(cur), pack_tap(e));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end else begin
                if (stalled) check("valid_dropped_in_stall", 0, 1);
                stalled = 1'b0;
            end
            if (done_n > 0 || err_n > 0) finished = 1'b1;
            if (finished) post++;
            if (post > 4) break;
            @(negedge clk);
        end
        ready = 1'b0;
        check("frame_terminates", finished, 1);
    endtask

    vec_t        vecs[8];
    logic [7:0]  fw_data[9];
    bit          fw_pad[9];
    int          mism, bad_pad;
    bit          quiet;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b0; sel = 1'b0;
        {cfg_h, cfg_w, cfg_k, cfg_s, cfg_p} = '0;
        vecs[0] = '{5, 5, 3, 1, 1, 5, 5, 225, 56, 1'b0};
        vecs[1] = '{5, 5, 3, 2, 0, 2, 2, 36, 0, 1'b0};
        vecs[2] = '{5, 5, 8, 1, 1, 0, 0, 0, 0, 1'b1};
        vecs[3] = '{4, 4, 0, 1, 0, 0, 0, 0, 0, 1'b1};
        vecs[4] = '{4, 4, 3, 0, 0, 0, 0, 0, 0, 1'b1};
        vecs[5] = '{3, 3, 5, 1, 1, 1, 1, 25, 16, 1'b0};
        vecs[6] = '{4, 6, 2, 3, 1, 2, 3, 24, 12, 1'b0};
        vecs[7] = '{9, 2, 5, 1, 1, 0, 0, 0, 0, 1'b1};
        fw_data = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd6, 8'd7};
        fw_pad  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_a", {busy_a, done_a, err_a, bus_a.pix_valid, bus_a.mem_rd_en, oh_a, ow_a}, '0);
        check("reset_b", {busy_b, done_b, err_b, bus_b.pix_valid, bus_b.mem_rd_en, oh_b, ow_b}, '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].h, vecs[i].w, vecs[i].k, vecs[i].s, vecs[i].p, 1'b0, 1'b0, !vecs[i].err);
            check($sformatf("v%0d/cfg_error", i), err_n, vecs[i].err ? 1 : 0);
            if (vecs[i].err) begin
                check($sformatf("v%0d/busy_never", i), busy_seen, 0);
                check($sformatf("v%0d/no_reads", i), rd_n, 0);
                check($sformatf("v%0d/no_done", i), done_n, 0);
            end else begin
                check($sformatf("v%0d/out_height", i), mon_oh, vecs[i].oh);
                check($sformatf("v%0d/out_width", i), mon_ow, vecs[i].ow);
                check($sformatf("v%0d/taps", i), taps_n, vecs[i].taps);
                check($sformatf("v%0d/pads", i), pads_n, vecs[i].pads);
                check($sformatf("v%0d/reads", i), rd_n, vecs[i].taps - vecs[i].pads);
                check($sformatf("v%0d/done_once", i), done_n, 1);
                check($sformatf("v%0d/busy_low_at_done", i), done_busy, 0);
                check($sformatf("v%0d/exp_left", i), exp_q.size(), 0);
            end
            if (i == 0) begin
                ref_q = recv_q;
                for (int j = 0; j < 9; j++)
                    check($sformatf("first_win/tap%0d", j),
                          {recv_q[j].data[7:0], recv_q[j].padded, recv_q[j].win_last},
                          {fw_data[j], fw_pad[j], (j == 8)});
            end
            if (i == 1) begin
                check("win11/first_data", recv_q[27].data, 24'd13);
                check("win11/last", {recv_q[35].data, recv_q[35].win_last, recv_q[35].frame_last},
                      {24'd25, 1'b1, 1'b1});
            end
        end

        // Back-pressure: same frame with pix_ready toggling.
        run_frame(5, 5, 3, 1, 1, 1'b0, 1'b1, 1'b1);
        check("stall/taps", taps_n, 225);
        check("stall/done_once", done_n, 1);
        check("stall/len_vs_ref", recv_q.size(), ref_q.size());
        mism = 0;
        for (int j = 0; j < recv_q.size() && j < ref_q.size(); j++)
            if (pack_tap(recv_q[j]) !== pack_tap(ref_q[j])) mism++;
        check("stall/seq_vs_ref", mism, 0);

        // Three packed channels with a non-zero pad value.
        run_frame(4, 4, 3, 1, 1, 1'b1, 1'b0, 1'b1);
        check("ch3/out_height", mon_oh, 4);
        check("ch3/out_width", mon_ow, 4);
        check("ch3/taps", taps_n, 144);
        check("ch3/pads", pads_n, 44);
        check("ch3/done_once", done_n, 1);
        bad_pad = 0;
        foreach (recv_q[j]) if (recv_q[j].padded && recv_q[j].data !== 24'h808080) bad_pad++;
        check("ch3/pad_word", bad_pad, 0);

        // Reset in the middle of RUN, then a clean frame.
        @(negedge clk);
        sel = 1'b0;
        cfg_h = 16'd5; cfg_w = 16'd5; cfg_k = 16'd3; cfg_s = 16'd1; cfg_p = 16'd1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ready = 1'b1;
        repeat (40) @(negedge clk);
        check("midrun/busy_before_rst", busy_a, 1);
        rst = 1'b1;
        #1;
        check("midrun/outputs_cleared",
              {busy_a, done_a, err_a, bus_a.pix_valid, bus_a.mem_rd_en, bus_a.pix_padded,
               bus_a.pix_win_last, bus_a.pix_frame_last, bus_a.pix_data, oh_a, ow_a}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done_a || busy_a) quiet = 1'b0;
        end
        check("midrun/no_done_after_rst", quiet, 1);
        run_frame(5, 5, 3, 1, 1, 1'b0, 1'b0, 1'b1);
        check("rerun/taps", taps_n, 225);
        check("rerun/done_once", done_n, 1);
        mism = 0;
        for (int j = 0; j < recv_q.size() && j < ref_q.size(); j++)
            if (pack_tap(recv_q[j]) !== pack_tap(ref_q[j])) mism++;
        check("rerun/seq_vs_ref", mism, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
Sequential successor to the combinational output-size and padding logic. On a start pulse it latches a convolution configuration and computes the output dimensions. It then walks every output position and every kernel tap, issuing reads to a synchronous input-feature RAM for in-range taps and substituting PAD_VALUE for out-of-range taps. It delivers a valid/ready tap stream to the MAC array, carrying all CHANNELS channels in each word.

Parameters:
COORD_WIDTH, 16, width of dimension/config fields and unsigned coordinates
DATA_WIDTH, 8, bits per channel sample
CHANNELS, 1, channels packed per RAM word (channel 0 in LSBs)
ADDR_WIDTH, 16, RAM address width
PAD_VALUE, 0, per-channel value emitted for padded taps

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_* when idle
cfg_in_height  in  COORD_WIDTH  input rows H
cfg_in_width  in  COORD_WIDTH  input columns W
cfg_kernel  in  COORD_WIDTH  square kernel size K
cfg_stride  in  COORD_WIDTH  stride S
cfg_padding  in  COORD_WIDTH  symmetric padding P
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last tap accepted
cfg_error  out  1  one-cycle pulse on illegal configuration
out_height  out  COORD_WIDTH  (H+2P-K)/S+1
out_width  out  COORD_WIDTH  (W+2P-K)/S+1
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_WIDTH  iy*W+ix, truncated
mem_rd_data  in  DATA_WIDTH*CHANNELS  valid from the cycle after mem_rd_en; RAM holds it until the next mem_rd_en
pix_valid  out  1  tap valid
pix_ready  in  1  consumer ready
pix_data  out  DATA_WIDTH*CHANNELS  tap data
pix_padded  out  1  tap is padding
pix_win_last  out  1  last tap (ky=kx=K-1) of a window
pix_frame_last  out  1  last tap of the frame

Behaviour:
- Reset: all outputs 0; out_height/out_width 0; FSM to IDLE; in-flight and output registers cleared. A reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, CHECK, SETUP, RUN, DRAIN.
- IDLE: start latches cfg_* and goes to CHECK. start is ignored while busy.
- CHECK (1 cycle): error if K=0, S=0, K>H+2P or K>W+2P.
  - On error: cfg_error pulses, return to IDLE, busy never rises, no reads issued.
  - Otherwise: busy=1, go to SETUP.
- SETUP: the two quotients are computed in parallel by repeated subtraction of S, one per cycle; no divider. out_height/out_width are updated on exit and held stable until the next accepted start. Go to RUN.
- RUN scan order: oy outer, then ox, ky, kx (kx fastest). Tap coordinates are iy=oy*S-P+ky and ix=ox*S-P+kx, signed, COORD_WIDTH+1 bits.
- A tap is in-range iff 0<=iy<H and 0<=ix<W.
  - In-range tap: mem_rd_en=1 with mem_addr for that tap.
  - Padded tap: no read; data=PAD_VALUE replicated per channel; pix_padded=1.
- Two-stage pipeline:
  - S1, the issue/in-flight stage, holds the padded and last flags.
  - S2 is the output register driving pix_*.
  - S2 loads from S1 when S2 is empty or pix_ready=1. It captures mem_rd_data, or PAD_VALUE for padded taps.
  - A new tap is issued into S1 only when S1 is empty or advancing this cycle.
- Timing: with pix_ready held 1, throughput is 1 tap/cycle and latency from issue to pix_valid is 2 cycles.
- pix_* and the RAM's held data stay stable while pix_valid=1 and pix_ready=0. No taps are dropped or duplicated.
- After the last tap is issued, go to DRAIN. When the frame-last tap is accepted (pix_valid&pix_ready), done pulses the next cycle, busy falls in the same cycle, and the FSM returns to IDLE.
- Total taps per frame: out_height*out_width*K*K.

Test Plan:
- H=W=5, K=3, S=1, P=1, pix_ready=1 -> out 5x5, 225 taps, done once.
  - First window flags: pad,pad,pad,pad, addr0, addr1, pad, addr5, addr6; pix_win_last on the 9th tap.
- H=W=5, K=3, S=2, P=0 -> out 2x2, 36 taps, no padded taps; window (oy=1,ox=1) first addr 12, last addr 24 with pix_frame_last.
- Case 1 with pix_ready toggled pseudo-randomly -> identical tap sequence to the ready=1 run; pix_data stable during stalls.
- K=8, H=W=5, P=1 -> cfg_error pulse, busy stays 0, mem_rd_en never asserted.
- CHANNELS=3, PAD_VALUE=8'h80, H=W=4, K=3, S=1, P=1 -> out 4x4; padded taps emit 24'h808080; in-range taps carry RAM words unmodified.
- rst asserted mid-RUN -> all outputs 0 immediately, no done; a new start runs the full frame correctly.
